// File: rtl/lfsr_share_ctrl_if.sv
// Bus bundle for lfsr_share_ctrl: per-requester configuration and requests in,
// arbitrated LFSR stream and status out.
interface lfsr_share_ctrl_if;
  logic [1:0] req;
  logic [3:0] seed0;
  logic [3:0] seed1;
  logic [4:0] len0;
  logic [4:0] len1;
  logic       psel0;
  logic       psel1;
  logic [1:0] grant;
  logic [3:0] q_out;
  logic       q_valid;
  logic [4:0] count;
  logic [1:0] done;
  logic       busy;

  modport master (
    output req, seed0, seed1, len0, len1, psel0, psel1,
    input  grant, q_out, q_valid, count, done, busy
  );

  modport slave (
    input  req, seed0, seed1, len0, len1, psel0, psel1,
    output grant, q_out, q_valid, count, done, busy
  );
endinterface

// File: rtl/lfsr_share_ctrl.sv
// One 4-bit LFSR shared round-robin between two requesters; each grant emits
// len values starting from the requester's seed, then pulses done.
module lfsr_share_ctrl (
  input  logic             clk,
  input  logic             rst,
  lfsr_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] done_q, done_d;
  logic [3:0] lfsr_q, lfsr_d;
  logic [4:0] count_q, count_d;
  logic [4:0] len_q, len_d;
  logic       psel_q, psel_d;
  logic       last_q, last_d;
  logic       q_valid_q, q_valid_d;
  logic       busy_q, busy_d;

  logic       owner;
  logic       owner_req;
  logic       winner;
  logic       fb;
  logic [3:0] seed_sel;

  assign owner     = grant_q[1];
  assign owner_req = owner ? bus.req[1] : bus.req[0];
  assign winner    = (bus.req == 2'b11) ? ~last_q : bus.req[1];
  assign seed_sel  = owner ? bus.seed1 : bus.seed0;
  assign fb        = psel_q ? (lfsr_q[3] ^ lfsr_q[0]) : (lfsr_q[3] ^ lfsr_q[2]);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lfsr_d  = lfsr_q;
    count_d = count_q;
    len_d   = len_q;
    psel_d  = psel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = LOAD;
          grant_d = winner ? 2'b10 : 2'b01;
        end
      end
      LOAD: begin
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner;
        end else begin
          len_d   = owner ? bus.len1 : bus.len0;
          psel_d  = owner ? bus.psel1 : bus.psel0;
          lfsr_d  = (seed_sel == '0) ? 4'b0001 : seed_sel;
          count_d = '0;
          state_d = (len_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort outranks normal completion, so a drop on the last value yields no done.
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner;
        end else if (count_q == len_q - 5'd1) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 5'd1;
          lfsr_d  = {lfsr_q[2:0], fb};
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = owner;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    // Outputs are registered from the next-state decode so they align with state_q.
    q_valid_d = (state_d == RUN);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE) ? grant_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      lfsr_q    <= '0;
      count_q   <= '0;
      len_q     <= '0;
      psel_q    <= 1'b0;
      last_q    <= 1'b1;
      q_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      lfsr_q    <= lfsr_d;
      count_q   <= count_d;
      len_q     <= len_d;
      psel_q    <= psel_d;
      last_q    <= last_d;
      q_valid_q <= q_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.q_out   = lfsr_q;
  assign bus.count   = count_q;
  assign bus.q_valid = q_valid_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Scoreboard bench for lfsr_share_ctrl: a sequence-level model queues expected
// values per grant and a negedge monitor consumes them as the DUT emits.
module tb_lfsr_share_ctrl;

  logic clk;
  logic rst;

  lfsr_share_ctrl_if bus ();

  lfsr_share_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] g;
    logic [4:0] c;
    logic [3:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] done_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       last_served;
  exp_t       mon_e;
  logic [1:0] mon_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Next value of a Fibonacci LFSR: shift left, new bit is parity of tapped bits.
  function automatic logic [3:0] next_val(input logic [3:0] s, input logic p);
    logic [3:0] taps;
    taps = p ? 4'b1001 : 4'b1100;
    return {s[2:0], ^(s & taps)};
  endfunction

  function automatic logic [1:0] onehot(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  // Queue the full expected stream for a grant to requester w.
  task automatic push_seq(input logic w, input int n_vals);
    logic [3:0] s;
    logic       p;
    exp_t       e;
    s = w ? bus.seed1 : bus.seed0;
    p = w ? bus.psel1 : bus.psel0;
    if (s == 4'd0) s = 4'd1;
    for (int i = 0; i < n_vals; i++) begin
      e.g = onehot(w);
      e.c = 5'(i);
      e.v = s;
      exp_q.push_back(e);
      s = next_val(s, p);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.q_valid) begin
        if (exp_q.size() == 0) begin
          chk("q_valid_unexpected", 32'(bus.q_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("valid_grant", 32'(bus.grant), 32'(mon_e.g));
          chk("count", 32'(bus.count), 32'(mon_e.c));
          chk("q_out", 32'(bus.q_out), 32'(mon_e.v));
        end
      end
      if (bus.done != 2'b00) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_owner", 32'(bus.done), 32'(mon_d));
        end
      end
    end
  end

  task automatic scramble();
    bus.seed0 = 4'($urandom);
    bus.seed1 = 4'($urandom);
    bus.len0  = 5'($urandom);
    bus.len1  = 5'($urandom);
    bus.psel0 = 1'($urandom);
    bus.psel1 = 1'($urandom);
  endtask

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_txn(input logic [1:0] r, input bit hold);
    logic w;
    int   len;
    int   n;
    w   = (r == 2'b11) ? ~last_served : r[1];
    len = w ? int'(bus.len1) : int'(bus.len0);
    bus.req = r;
    push_seq(w, len);
    done_q.push_back(onehot(w));
    @(posedge clk) #1;
    chk("grant", 32'(bus.grant), 32'(onehot(w)));
    chk("busy", 32'(bus.busy), 32'd1);
    n = 0;
    do begin
      @(posedge clk) #1;
      n++;
      if (!hold && n == 1) scramble();
    end while (bus.done == 2'b00 && n < 40);
    chk("done_latency", 32'(n), 32'(len + 1));
    chk("done_valid_low", 32'(bus.q_valid), 32'd0);
    if (!hold) bus.req = 2'b00;
    last_served = w;
    @(posedge clk) #1;
    chk("idle_grant", 32'(bus.grant), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_q_out", 32'(bus.q_out), 32'd0);
    chk("rst_q_valid", 32'(bus.q_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    bus.req   = 2'b00;
    bus.seed0 = 4'd0;
    bus.seed1 = 4'd0;
    bus.len0  = 5'd0;
    bus.len1  = 5'd0;
    bus.psel0 = 1'b0;
    bus.psel1 = 1'b0;
    last_served = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    // Requester 0, x^4+x+1 from 0001
    bus.seed0 = 4'b0001; bus.psel0 = 1'b1; bus.len0 = 5'd4;
    run_txn(2'b01, 0);
    // Requester 1, x^4+x^3+1 from 0001
    bus.seed1 = 4'b0001; bus.psel1 = 1'b0; bus.len1 = 5'd4;
    run_txn(2'b10, 0);

    // Sustained contention alternates owners
    bus.seed0 = 4'b1010; bus.psel0 = 1'b0; bus.len0 = 5'd2;
    bus.seed1 = 4'b0110; bus.psel1 = 1'b1; bus.len1 = 5'd2;
    run_txn(2'b11, 1);
    run_txn(2'b11, 1);
    run_txn(2'b11, 0);

    // Zero seed substitution, then zero length
    bus.seed0 = 4'b0000; bus.psel0 = 1'b1; bus.len0 = 5'd1;
    run_txn(2'b01, 0);
    bus.seed0 = 4'b0101; bus.len0 = 5'd0;
    run_txn(2'b01, 0);

    // Abort after two values of eight
    bus.seed0 = 4'b1100; bus.psel0 = 1'b0; bus.len0 = 5'd8;
    bus.req = 2'b01;
    push_seq(1'b0, 2);
    @(posedge clk) #1;
    chk("abort_grant", 32'(bus.grant), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    bus.req = 2'b00;
    @(posedge clk) #1;
    chk("abort_q_valid", 32'(bus.q_valid), 32'd0);
    chk("abort_grant_clear", 32'(bus.grant), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    last_served = 1'b0;
    bus.seed1 = 4'b0011; bus.psel1 = 1'b1; bus.len1 = 5'd3;
    run_txn(2'b11, 0);

    // Asynchronous reset mid-run, then restart from seed0
    bus.seed0 = 4'b1001; bus.psel0 = 1'b1; bus.len0 = 5'd10;
    bus.req = 2'b01;
    push_seq(1'b0, 10);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    done_q.delete();
    last_served = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_txn(2'b01, 0);

    // Randomized traffic, including full-length wrap
    for (int t = 0; t < 25; t++) begin
      bus.seed0 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      bus.seed1 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      bus.len0  = (t % 8 == 3) ? 5'd31 : 5'($urandom_range(0, 31));
      bus.len1  = (t % 8 == 6) ? 5'd31 : 5'($urandom_range(0, 31));
      bus.psel0 = 1'($urandom);
      bus.psel1 = 1'($urandom);
      run_txn(2'($urandom_range(1, 3)), 0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("leftover_values", 32'(exp_q.size()), 32'd0);
    chk("leftover_done", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
